// File: rtl/lane_pkg.sv
// Shared lane constants and the tick-generator state type, also used by the
// lane position counters.
package lane_pkg;

    typedef enum logic [1:0] {
        LANE_IDLE   = 2'd0,
        LANE_RUN    = 2'd1,
        LANE_PAUSED = 2'd2
    } lane_tick_state_t;

    localparam int LANE_BASE_DIV = 500000;
    localparam int LANE_MIN_DIV  = 1000;

endpackage

// File: rtl/tick_period_calc.sv
// Combinational tick period: period = max(BASE_DIV >> level, MIN_DIV),
// evaluated in DIV_W bits.
module tick_period_calc
    import lane_pkg::*;
#(
    parameter int DIV_W    = 20,
    parameter int BASE_DIV = LANE_BASE_DIV,
    parameter int MIN_DIV  = LANE_MIN_DIV,
    parameter int LEVEL_W  = 3
) (
    input  logic [LEVEL_W-1:0] i_level,
    output logic [DIV_W-1:0]   o_period
);

    logic [DIV_W-1:0] w_shifted;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        w_shifted = DIV_W'(BASE_DIV) >> i_level;
        o_period  = (w_shifted < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : w_shifted;
    end

endmodule

// File: rtl/lane_tick_gen.sv
// Motion-tick generator for the lane counters: single-cycle tick every
// level-dependent period, with run/stop and an 8-bit wrapping tally.
// Optional pause freeze is built only when LANE_TICK_PAUSE_EN is defined.
module lane_tick_gen
    import lane_pkg::*;
#(
    parameter int DIV_W    = 20,
    parameter int BASE_DIV = LANE_BASE_DIV,
    parameter int MIN_DIV  = LANE_MIN_DIV,
    parameter int LEVEL_W  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
`ifdef LANE_TICK_PAUSE_EN
    input  logic               pause,
`endif
    input  logic [LEVEL_W-1:0] level,
    output logic               tick,
    output logic               running,
    output logic [7:0]         tick_cnt
);

`ifdef LANE_TICK_PAUSE_EN
    localparam int ST_W = 2;
`else
    localparam int ST_W = 1;
`endif

    localparam logic [ST_W-1:0] S_IDLE   = ST_W'(LANE_IDLE);
    localparam logic [ST_W-1:0] S_RUN    = ST_W'(LANE_RUN);
`ifdef LANE_TICK_PAUSE_EN
    localparam logic [ST_W-1:0] S_PAUSED = ST_W'(LANE_PAUSED);
`endif

    logic [ST_W-1:0]  r_state;
    logic [DIV_W-1:0] r_div;
    logic             r_tick;
    logic [7:0]       r_tick_cnt;

    logic [DIV_W-1:0] w_period;
    logic [DIV_W-1:0] w_reload;
    logic             w_pause;
    logic             w_count;

    tick_period_calc #(
        .DIV_W    (DIV_W),
        .BASE_DIV (BASE_DIV),
        .MIN_DIV  (MIN_DIV),
        .LEVEL_W  (LEVEL_W)
    ) u_period_calc (
        .i_level  (level),
        .o_period (w_period)
    );

    assign w_reload = w_period - DIV_W'(1);

`ifdef LANE_TICK_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    // The edge that leaves PAUSED also counts, so a P-cycle pause costs exactly P cycles.
    assign w_count = !stop && !w_pause && (r_state != S_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_tick     <= 1'b0;
            r_tick_cnt <= '0;
        end else begin
            r_tick <= 1'b0;

            if (stop) begin
                r_state <= S_IDLE;
            end else if (r_state == S_IDLE) begin
                if (start) begin
                    r_state    <= S_RUN;
                    r_div      <= w_reload;
                    r_tick_cnt <= '0;
                end
`ifdef LANE_TICK_PAUSE_EN
            end else if (w_pause) begin
                r_state <= S_PAUSED;
            end else begin
                r_state <= S_RUN;
`endif
            end

            if (w_count) begin
                if (r_div == '0) begin
                    r_tick     <= 1'b1;
                    r_div      <= w_reload;
                    r_tick_cnt <= r_tick_cnt + 8'd1;
                end else begin
                    r_div <= r_div - DIV_W'(1);
                end
            end
        end
    end

    assign tick     = r_tick;
    assign running  = (r_state != S_IDLE);
    assign tick_cnt = r_tick_cnt;

endmodule

// File: tb/tb_lane_tick_gen.sv
// Self-checking bench for lane_tick_gen (BASE_DIV=16, MIN_DIV=4, LEVEL_W=3);
// pause scenarios are exercised when LANE_TICK_PAUSE_EN is defined.
module tb_lane_tick_gen;

    localparam int BASE = 16;
    localparam int MINP = 4;
    localparam int LW   = 3;
`ifdef LANE_TICK_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          stop;
`ifdef LANE_TICK_PAUSE_EN
    logic          pause;
`endif
    logic [LW-1:0] level;
    logic          tick;
    logic          running;
    logic [7:0]    tick_cnt;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;

    // Behavioural model: edges remaining until the next tick, plus run flag and tally.
    bit m_run;
    bit m_tick;
    int m_rem;
    int m_cnt;

    lane_tick_gen #(
        .DIV_W    (20),
        .BASE_DIV (BASE),
        .MIN_DIV  (MINP),
        .LEVEL_W  (LW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
`ifdef LANE_TICK_PAUSE_EN
        .pause    (pause),
`endif
        .level    (level),
        .tick     (tick),
        .running  (running),
        .tick_cnt (tick_cnt)
    );

    always #5 clk = ~clk;

    function automatic int period_of(input int lv);
        int p;
        p = BASE >> lv;
        return (p < MINP) ? MINP : p;
    endfunction

    // Drives one cycle of inputs, advances one edge, updates the model, samples 1ns later.
    task automatic step(input bit rst, input bit st, input bit sp, input bit ps, input int lv);
        reset = rst;
        start = st;
        stop  = sp;
`ifdef LANE_TICK_PAUSE_EN
        pause = ps;
`endif
        level = LW'(lv);
        @(posedge clk);
        edge_n++;
        m_tick = 1'b0;
        if (rst) begin
            m_run = 1'b0;
            m_cnt = 0;
            m_rem = 0;
        end else if (sp) begin
            m_run = 1'b0;
        end else if (!m_run) begin
            if (st) begin
                m_run = 1'b1;
                m_rem = period_of(lv);
                m_cnt = 0;
            end
        end else if (!(ps && PAUSE_EN)) begin
            m_rem--;
            if (m_rem == 0) begin
                m_tick = 1'b1;
                m_cnt  = (m_cnt + 1) % 256;
                m_rem  = period_of(lv);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 0);
            total++;
            if ({tick, running, tick_cnt} !== 10'd0) begin
                bad++;
                $display("FAIL reset: tick=%b running=%b tick_cnt=%0d, want all 0", tick, running, tick_cnt);
            end
        end
        step(0, 0, 0, 0, 0);
        total++;
        if ({tick, running, tick_cnt} !== {m_tick, m_run, 8'(m_cnt)}) begin
            bad++;
            $display("FAIL reset_release: got %b/%b/%0d want %b/%b/%0d", tick, running, tick_cnt, m_tick, m_run, m_cnt);
        end
    endtask

    task automatic test_level0();
        int s;
        int d;
        bit exp_tick;
        while (edge_n < 9) step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        s = edge_n;
        total++;
        if (running !== 1'b1 || tick_cnt !== 8'd0) begin
            bad++;
            $display("FAIL level0_start: running=%b tick_cnt=%0d at edge %0d, want 1/0", running, tick_cnt, s);
        end
        for (int i = 0; i < 50; i++) begin
            step(0, 0, 0, 0, 0);
            d = edge_n - s;
            exp_tick = (d % 16 == 0);
            total++;
            if (tick !== exp_tick || running !== 1'b1 || tick_cnt !== 8'(d / 16)) begin
                bad++;
                $display("FAIL level0 d=%0d: tick=%b cnt=%0d want tick=%b cnt=%0d", d, tick, tick_cnt, exp_tick, d / 16);
            end
        end
        step(0, 0, 1, 0, 0);
    endtask

    task automatic test_levels();
        int s;
        int d;
        int lvs [2] = '{2, 3};
        foreach (lvs[k]) begin
            step(0, 1, 0, 0, lvs[k]);
            s = edge_n;
            for (int i = 0; i < 20; i++) begin
                step(0, 0, 0, 0, lvs[k]);
                d = edge_n - s;
                total++;
                if (tick !== (d % 4 == 0) || tick_cnt !== 8'(d / 4) || tick !== m_tick) begin
                    bad++;
                    $display("FAIL level%0d d=%0d: tick=%b cnt=%0d want tick=%b cnt=%0d", lvs[k], d, tick, tick_cnt, (d % 4 == 0), d / 4);
                end
            end
            step(0, 0, 1, 0, 0);
        end
    endtask

    task automatic test_level_change();
        int s;
        int d;
        bit exp_tick;
        step(0, 1, 0, 0, 0);
        s = edge_n;
        for (int i = 0; i < 32; i++) begin
            step(0, 0, 0, 0, (i < 8) ? 0 : 2);
            d = edge_n - s;
            exp_tick = (d == 16) || (d > 16 && (d - 16) % 4 == 0);
            total++;
            if (tick !== exp_tick || {tick, running, tick_cnt} !== {m_tick, m_run, 8'(m_cnt)}) begin
                bad++;
                $display("FAIL level_change d=%0d: tick=%b cnt=%0d want tick=%b cnt=%0d", d, tick, tick_cnt, exp_tick, m_cnt);
            end
        end
        step(0, 0, 1, 0, 0);
    endtask

    task automatic test_pause();
        int s;
        int d;
        bit ps;
        step(0, 1, 0, 0, 0);
        s = edge_n;
        for (int i = 0; i < 24; i++) begin
            d  = edge_n - s + 1;
            ps = (PAUSE_EN && d >= 7 && d <= 11);
            step(0, 0, 0, ps, 0);
            total++;
            if (tick !== ((PAUSE_EN ? 21 : 16) == d) || running !== 1'b1 ||
                tick_cnt !== 8'(d >= (PAUSE_EN ? 21 : 16))) begin
                bad++;
                $display("FAIL pause d=%0d: tick=%b running=%b cnt=%0d", d, tick, running, tick_cnt);
            end
        end
        step(0, 0, 1, 0, 0);
    endtask

    task automatic test_stop_pause();
        for (int i = 0; i < 20; i++) step(0, (i == 0), 0, 0, 0);
        total++;
        if (tick_cnt !== 8'd1) begin
            bad++;
            $display("FAIL stop_pause_pre: tick_cnt=%0d want 1", tick_cnt);
        end
        step(0, 0, 1, 1, 0);
        total++;
        if (running !== 1'b0 || tick !== 1'b0) begin
            bad++;
            $display("FAIL stop_pause: running=%b tick=%b want 0/0", running, tick);
        end
        step(0, 1, 0, 0, 0);
        total++;
        if (running !== 1'b1 || tick_cnt !== 8'd0) begin
            bad++;
            $display("FAIL restart_clear: running=%b tick_cnt=%0d want 1/0", running, tick_cnt);
        end
        step(0, 0, 1, 0, 0);
    endtask

    task automatic test_reset_before_tick();
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 15; i++) step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        total++;
        if ({tick, running, tick_cnt} !== 10'd0) begin
            bad++;
            $display("FAIL reset_before_tick: tick=%b running=%b cnt=%0d want 0/0/0", tick, running, tick_cnt);
        end
        step(0, 0, 0, 0, 0);
        total++;
        if ({tick, running, tick_cnt} !== 10'd0) begin
            bad++;
            $display("FAIL reset_after: tick=%b running=%b cnt=%0d want 0/0/0", tick, running, tick_cnt);
        end
    endtask

    task automatic test_wrap();
        step(0, 1, 0, 0, 3);
        for (int i = 0; i < 1200; i++) begin
            step(0, 0, 0, 0, 3);
            if ({tick, running, tick_cnt} !== {m_tick, m_run, 8'(m_cnt)}) begin
                total++;
                bad++;
                $display("FAIL wrap_track i=%0d: cnt=%0d want %0d", i, tick_cnt, m_cnt);
            end
        end
        total++;
        if (tick !== 1'b1 || tick_cnt !== 8'd44) begin
            bad++;
            $display("FAIL wrap: tick=%b tick_cnt=%0d want 1/44", tick, tick_cnt);
        end
        step(0, 0, 1, 0, 0);
    endtask

    task automatic test_random();
        bit rst, st, sp, ps;
        int lv;
        int ps_left = 0;
        lv = 0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            sp  = ($urandom_range(0, 59) == 0);
            st  = ($urandom_range(0, 9) == 0);
            if (ps_left == 0 && $urandom_range(0, 15) == 0) ps_left = $urandom_range(1, 8);
            ps = (ps_left > 0);
            if (ps_left > 0) ps_left--;
            if ($urandom_range(0, 19) == 0) lv = $urandom_range(0, 7);
            step(rst, st, sp, ps, lv);
            total++;
            if ({tick, running, tick_cnt} !== {m_tick, m_run, 8'(m_cnt)}) begin
                bad++;
                $display("FAIL random i=%0d: got %b/%b/%0d want %b/%b/%0d", i, tick, running, tick_cnt, m_tick, m_run, m_cnt);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
`ifdef LANE_TICK_PAUSE_EN
        pause = 1'b0;
`endif
        level = '0;
        m_run = 1'b0;
        m_tick = 1'b0;
        m_rem = 0;
        m_cnt = 0;
        test_reset();
        test_level0();
        test_levels();
        test_level_change();
        test_pause();
        test_stop_pause();
        test_reset_before_tick();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
